// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
//   OVERSAMPLE : sample ticks per bit period
//   DATA_BITS  : payload bits per frame
//   BAUD_DIV   : tick-counter reload value per baud_select code; tick period is DIV+1 clks
//   uart_rx_state_t : receiver FSM state encoding
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned DIV_W      = 14;

    localparam logic [DIV_W-1:0] BAUD_DIV [8] = '{
        14'd10417, 14'd2604, 14'd651, 14'd326, 14'd163, 14'd81, 14'd54, 14'd27
    };

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side signal bundle.
//   baud_select, RX_EN, RxD             : driven by the line/control side (master)
//   Rx_DATA, Rx_VALID, Rx_PERROR,
//   Rx_FERROR, RX_BUSY                  : driven by the receiver (slave)
interface uart_receiver_if;

    logic [2:0]                     baud_select;
    logic                           RX_EN;
    logic                           RxD;
    logic [uart_pkg::DATA_BITS-1:0] Rx_DATA;
    logic                           Rx_VALID;
    logic                           Rx_PERROR;
    logic                           Rx_FERROR;
    logic                           RX_BUSY;

    modport master (
        output baud_select, RX_EN, RxD,
        input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, RX_BUSY
    );

    modport slave (
        input  baud_select, RX_EN, RxD,
        output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, RX_BUSY
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator.
//   clk, reset   : system clock, synchronous active-high reset
//   baud_select  : baud code; selects the reload value from BAUD_DIV
//   sample_tick  : one-clk pulse every DIV+1 clks
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_tick
);

    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cnt_q == '0) begin
            cnt_q <= BAUD_DIV[baud_select];
        end else begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

    assign sample_tick = (cnt_q == '0);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start, 8 data bits LSB-first, even parity, stop; 16x oversampling.
//   clk, reset : system clock, synchronous active-high reset
//   rx         : slave side of uart_receiver_if (line input, enable, baud code,
//                received byte, valid pulse, parity/framing flags, busy)
module uart_receiver #(
    parameter int unsigned OVERSAMPLE  = uart_pkg::OVERSAMPLE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    uart_receiver_if.slave rx
);

    import uart_pkg::*;

    localparam int unsigned CW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS);
    // Sample point: tick 7 of 16, i.e. mid-bit counted from the start-detect tick.
    localparam logic [CW-1:0] MID = CW'(OVERSAMPLE / 2 - 1);

    localparam logic [2:0] IDLE   = StIdle;
    localparam logic [2:0] START  = StStart;
    localparam logic [2:0] DATA   = StData;
    localparam logic [2:0] PARITY = StParity;
    localparam logic [2:0] STOP   = StStop;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   sample_tick;
    logic [2:0]             tick_sel;

    logic [2:0]           state_q, state_d;
    logic [2:0]           baud_q, baud_d;
    logic [CW-1:0]        scnt_q, scnt_d, scnt_inc;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx.RxD};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // In IDLE the tick follows the live code so the start edge is found at the right rate;
    // from START onwards the code captured at start detection is used.
    assign tick_sel = (state_q == IDLE) ? rx.baud_select : baud_q;

    uart_baud_tick u_tick (
        .clk         (clk),
        .reset       (reset),
        .baud_select (tick_sel),
        .sample_tick (sample_tick)
    );

    assign scnt_inc = scnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        scnt_d     = scnt_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        data_d     = data_q;
        perr_out_d = perr_out_q;
        ferr_d     = ferr_q;
        valid_d    = 1'b0;

        if (!rx.RX_EN) begin
            state_d = IDLE;
        end else if (sample_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        scnt_d  = '0;
                        baud_d  = rx.baud_select;
                    end
                end
                START: begin
                    scnt_d = scnt_inc;
                    if (scnt_inc == MID) begin
                        if (rxs) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            bcnt_d  = '0;
                        end
                    end
                end
                DATA: begin
                    // Counter free-runs and wraps, so every bit is sampled OVERSAMPLE ticks apart.
                    scnt_d = scnt_inc;
                    if (scnt_inc == MID) begin
                        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                        bcnt_d  = bcnt_q + BW'(1);
                        if (bcnt_q == BW'(DATA_BITS - 1)) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    scnt_d = scnt_inc;
                    if (scnt_inc == MID) begin
                        perr_d  = rxs ^ (^shift_q);
                        state_d = STOP;
                    end
                end
                STOP: begin
                    scnt_d = scnt_inc;
                    if (scnt_inc == MID) begin
                        // Return to IDLE at mid-stop so a start bit right after is caught.
                        data_d     = shift_q;
                        perr_out_d = perr_q;
                        ferr_d     = ~rxs;
                        valid_d    = ~perr_q & rxs;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            scnt_q     <= '0;
            bcnt_q     <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            scnt_q     <= scnt_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx.Rx_DATA   = data_q;
    assign rx.Rx_VALID  = valid_q;
    assign rx.Rx_PERROR = perr_out_q;
    assign rx.Rx_FERROR = ferr_q;
    assign rx.RX_BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table-driven frames plus hand-written
// sequences for false start, mid-frame reset and mid-frame RX_EN drop.
module tb_uart_receiver;

    logic clk = 1'b0;
    logic reset;

    always #10 clk = ~clk;

    uart_receiver_if bus ();

    uart_receiver #(
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (bus)
    );

    localparam int DIVS [8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [2:0] baud;
        int         gap_bits;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        int         exp_pulses;
    } vec_t;

    vec_t vecs [7];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses = 0;
    int wide   = 0;
    int last_valid = 0;
    logic prev_v = 1'b0;
    int bit_clks = 448;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.Rx_VALID === 1'b1) begin
            pulses     <= pulses + 1;
            last_valid <= cyc;
            if (prev_v) wide <= wide + 1;
        end
        prev_v <= (bus.Rx_VALID === 1'b1);
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_baud(input logic [2:0] b);
        bus.baud_select = b;
        bit_clks = 16 * (DIVS[b] + 1);
    endtask

    task automatic send_bit(input logic b);
        bus.RxD = b;
        repeat (bit_clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int nbits);
        logic [10:0] fr;
        fr = {s, p, d, 1'b0};
        start_cyc = cyc;
        for (int k = 0; k < nbits; k++) send_bit(fr[k]);
        bus.RxD = 1'b1;
    endtask

    task automatic run_vec(input int i);
        int p0;
        int lat;
        p0 = pulses;
        set_baud(vecs[i].baud);
        send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, 11);
        check($sformatf("v%0d_data", i), 32'(bus.Rx_DATA), 32'(vecs[i].exp_data));
        check($sformatf("v%0d_perr", i), 32'(bus.Rx_PERROR), 32'(vecs[i].exp_perr));
        check($sformatf("v%0d_ferr", i), 32'(bus.Rx_FERROR), 32'(vecs[i].exp_ferr));
        if (i == 0) begin
            // Valid edge = start-detect tick + 167 ticks of 28 clks; detection lands
            // 3..30 clks after the line falls.
            lat = last_valid - start_cyc;
            total++;
            if (lat < 4679 || lat > 4706) begin
                bad++;
                $display("FAIL v0_valid_latency: actual=%0d required=4679..4706", lat);
            end
        end
        repeat (vecs[i].gap_bits * bit_clks) @(negedge clk);
        check($sformatf("v%0d_pulses", i), 32'(pulses - p0), 32'(vecs[i].exp_pulses));
        check($sformatf("v%0d_busy", i), 32'(bus.RX_BUSY), 32'd0);
    endtask

    initial begin
        int p0;
        int busy_seen;

        //          data   par   stop  baud  gap exp_d  perr  ferr  pulses
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 3'd7, 1,  8'hA5, 1'b0, 1'b0, 1};
        vecs[1] = '{8'h07, 1'b0, 1'b1, 3'd7, 1,  8'h07, 1'b1, 1'b0, 0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 3'd7, 12, 8'h3C, 1'b0, 1'b1, 0};
        vecs[3] = '{8'h81, 1'b0, 1'b1, 3'd7, 1,  8'h81, 1'b0, 1'b0, 1};
        vecs[4] = '{8'h5A, 1'b0, 1'b1, 3'd7, 1,  8'h5A, 1'b0, 1'b0, 1};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 3'd6, 0,  8'h00, 1'b0, 1'b0, 1};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 3'd6, 1,  8'hFF, 1'b0, 1'b0, 1};

        reset = 1'b1;
        bus.RxD = 1'b1;
        bus.RX_EN = 1'b1;
        set_baud(3'd7);
        repeat (3) @(negedge clk);
        check("rst_data", 32'(bus.Rx_DATA), 32'd0);
        check("rst_valid", 32'(bus.Rx_VALID), 32'd0);
        check("rst_perr", 32'(bus.Rx_PERROR), 32'd0);
        check("rst_ferr", 32'(bus.Rx_FERROR), 32'd0);
        check("rst_busy", 32'(bus.RX_BUSY), 32'd0);
        reset = 1'b0;
        repeat (100) @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(i);

        // False start: 84-clk low glitch.
        p0 = pulses;
        busy_seen = 0;
        bus.RxD = 1'b0;
        repeat (84) begin
            @(negedge clk);
            if (bus.RX_BUSY === 1'b1) busy_seen = 1;
        end
        bus.RxD = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (bus.RX_BUSY === 1'b1) busy_seen = 1;
        end
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_busy_after", 32'(bus.RX_BUSY), 32'd0);
        check("glitch_data", 32'(bus.Rx_DATA), 32'h81);
        check("glitch_perr", 32'(bus.Rx_PERROR), 32'd0);
        check("glitch_ferr", 32'(bus.Rx_FERROR), 32'd0);
        check("glitch_pulses", 32'(pulses - p0), 32'd0);

        // Reset after data bit 3 of 0x12.
        send_frame(8'h12, 1'b0, 1'b1, 5);
        check("midrst_busy_before", 32'(bus.RX_BUSY), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_data", 32'(bus.Rx_DATA), 32'd0);
        check("midrst_valid", 32'(bus.Rx_VALID), 32'd0);
        check("midrst_perr", 32'(bus.Rx_PERROR), 32'd0);
        check("midrst_ferr", 32'(bus.Rx_FERROR), 32'd0);
        check("midrst_busy", 32'(bus.RX_BUSY), 32'd0);
        repeat (2 * bit_clks) @(negedge clk);
        run_vec(4);

        // Back-to-back frames at baud code 110.
        run_vec(5);
        run_vec(6);

        // RX_EN drop mid-frame.
        p0 = pulses;
        send_frame(8'h55, 1'b0, 1'b1, 4);
        check("en_busy_before", 32'(bus.RX_BUSY), 32'd1);
        bus.RX_EN = 1'b0;
        @(negedge clk);
        check("en_busy_next_clk", 32'(bus.RX_BUSY), 32'd0);
        repeat (2 * bit_clks) @(negedge clk);
        bus.RX_EN = 1'b1;
        repeat (2 * bit_clks) @(negedge clk);
        check("en_pulses", 32'(pulses - p0), 32'd0);
        check("en_data", 32'(bus.Rx_DATA), 32'hFF);
        check("en_busy_after", 32'(bus.RX_BUSY), 32'd0);

        check("valid_width", 32'(wide), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
